axi4lite_register_bank: RTL and testbench
=========================================

Name: axi4lite_register_bank

Overview:
- Parametrised bank of NUM_REGS byte-strobed registers.
- Each register has its own access mode: RW, RO, W1C, W1S or PULSE.
- Sits between the AXI4-Lite slave front-end (the decoded write/read strobes) and user logic.
- Adds a registered read path, hardware set inputs for status bits and an address-range error flag.

Parameters:
- DATA_WIDTH, 32: register width in bits; must be a multiple of 8.
- NUM_REGS, 8: number of registers, 1..256.
- ADDR_WIDTH, 3: word-address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- REG_MODES, 0: NUM_REGS*3 bits; field [i*3+:3] is register i's mode. 0 RW, 1 RO, 2 W1C, 3 W1S, 4 PULSE; 5-7 behave as RO.
- RESET_VALUES, 0: NUM_REGS*DATA_WIDTH bits; field [i*DATA_WIDTH+:DATA_WIDTH] is register i's reset value.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe, one cycle per write.
- wr_addr  in  ADDR_WIDTH  word address of the write.
- wstrb  in  DATA_WIDTH/8  byte enables of the write.
- wdata  in  DATA_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  word address of the read.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid while high.
- addr_err  out  1  one-cycle pulse: access to an address >= NUM_REGS.
- hw_in  in  NUM_REGS*DATA_WIDTH  values returned by RO registers.
- hw_set  in  NUM_REGS*DATA_WIDTH  per-bit set inputs for W1C registers.
- regs_out  out  NUM_REGS*DATA_WIDTH  current stored value of every register.

Behaviour:
- Reset (reset low, asynchronous):
  - Each stored register takes its RESET_VALUES field; PULSE registers clear to 0 regardless.
  - rd_data=0, rd_valid=0, addr_err=0.
  - Release is synchronous to clk; the first write is accepted on the first rising edge with reset high.
- Write, when wr_en=1 and wr_addr<NUM_REGS; only bytes with wstrb[b]=1 are affected; result visible on regs_out the next cycle:
  - RW: byte <= wdata byte.
  - RO: write ignored. Stored value stays at its reset value; reads return hw_in.
  - W1C: bits written 1 clear; bits written 0 are unchanged.
  - W1S: bits written 1 set; bits written 0 are unchanged.
  - PULSE: bits written 1 are high for exactly one cycle, then return to 0 automatically.
- W1C hardware set: a hw_set bit sets the stored bit every cycle it is high. If hw_set and a W1C clear hit the same bit in the same cycle, set wins and the bit reads 1.
- hw_set is ignored for non-W1C registers.
- Read: rd_en=1 in cycle N gives rd_valid=1 and rd_data in cycle N+1.
  - rd_data is the pre-write stored value, or hw_in sampled at cycle N for RO.
  - A same-cycle write to the same address is not reflected until the next read.
  - A PULSE register reads its current value; when read in the cycle after its write, it reads 1 for the pulsed bits.
- Address error: wr_addr>=NUM_REGS with wr_en, or rd_addr>=NUM_REGS with rd_en:
  - No register changes.
  - A read still gives rd_valid=1 with rd_data=0.
  - addr_err pulses in cycle N+1.
- Simultaneous rd_en and wr_en are both serviced independently in the same cycle.
- Back-to-back reads every cycle give rd_valid high every cycle (full throughput).
- Reset asserted mid-read: rd_valid drops immediately and no pending read completes.

Optional Feature:
- Macro REG_BANK_SHADOW_EN.
- Defined:
  - Adds input commit (1 bit).
  - RW and W1S writes update a shadow copy only. regs_out, and reads of those registers, show the active copy.
  - commit=1 copies shadow to active in one cycle; a write in the same cycle as commit lands in both copies.
  - Reset sets both copies to RESET_VALUES.
  - W1C, PULSE and RO registers are unaffected.
- Undefined: no commit port; writes act directly as described above.

Test Plan:
- Reset, RESET_VALUES reg1=0xDEADBEEF -> regs_out reg1=0xDEADBEEF, rd_valid=0; read addr1 -> rd_data=0xDEADBEEF one cycle later.
- RW reg0, write 0x11223344 wstrb=4'b0101 over 0xAAAAAAAA -> reg0=0xAA22AA44.
- W1C reg2: hw_set=0x0F for one cycle -> reg2=0x0F; write 0x05 -> reg2=0x0A. Write 0x02 together with hw_set=0x02 -> reg2=0x0A (set wins).
- PULSE reg3, write 0x80 -> regs_out reg3=0x80 for exactly one cycle, then 0x00; W1S reg4 write 0x1 then 0x2 -> 0x3.
- NUM_REGS=6: read addr 7 -> rd_valid=1, rd_data=0, addr_err=1. Write addr 6 -> no register changes, addr_err=1.
- RO reg5, hw_in=0x12345678, write 0xFFFFFFFF -> read returns 0x12345678. Reset pulse mid-read -> rd_valid=0.

Source files
------------

// File: rtl/axi4lite_register_bank.sv
// axi4lite_register_bank
//
// A bank of NUM_REGS byte-strobed registers that sits between the decoded
// write/read strobes of an AXI4-Lite slave front-end and user logic.
//
// Each register has its own access mode, taken from REG_MODES[i*3+:3]:
//   0 RW     - plain read/write register
//   1 RO     - writes ignored; reads return hw_in, regs_out shows the reset value
//   2 W1C    - writing 1 clears a bit; hw_set bits set it (set beats clear)
//   3 W1S    - writing 1 sets a bit
//   4 PULSE  - bits written 1 are high for one cycle, then self-clear
//   5..7     - treated as RO
//
// Configuration macro: REG_BANK_SHADOW_EN
//   When defined, RW and W1S registers get a shadow copy. Writes land in the
//   shadow only, and the 'commit' input copies shadow to active. A write in
//   the same cycle as commit reaches both copies.
//   When undefined, there is no commit port and writes act directly.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   wr_en     in   write strobe, one cycle per write
//   wr_addr   in   word address of the write
//   wstrb     in   byte enables of the write
//   wdata     in   write data
//   commit    in   shadow-to-active copy (REG_BANK_SHADOW_EN only)
//   rd_en     in   read strobe
//   rd_addr   in   word address of the read
//   rd_data   out  registered read data
//   rd_valid  out  one-cycle pulse, rd_data valid while high
//   addr_err  out  one-cycle pulse for an access to an address >= NUM_REGS
//   hw_in     in   values returned by reads of RO registers
//   hw_set    in   per-bit set inputs for W1C registers
//   regs_out  out  current stored (active) value of every register

module axi4lite_register_bank #(
  parameter int                             DATA_WIDTH   = 32,
  parameter int                             NUM_REGS     = 8,
  parameter int                             ADDR_WIDTH   = 3,
  parameter logic [NUM_REGS*3-1:0]          REG_MODES    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [DATA_WIDTH-1:0]          wdata,
`ifdef REG_BANK_SHADOW_EN
  input  logic                           commit,
`endif
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic                           addr_err,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  typedef enum logic [2:0] {
    MODE_RW    = 3'd0,
    MODE_RO    = 3'd1,
    MODE_W1C   = 3'd2,
    MODE_W1S   = 3'd3,
    MODE_PULSE = 3'd4
  } reg_mode_e;

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_A = (ADDR_WIDTH + 1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] byte_mask;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] read_val [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_mux;

  // Only some slices of hw_in / hw_set are meaningful, depending on modes.
  logic unused_hw;
  assign unused_hw = ^{hw_in, hw_set};

  // Expand byte enables to a per-bit mask.
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      byte_mask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  assign wr_in_range = ({1'b0, wr_addr} < NUM_REGS_A);
  assign rd_in_range = ({1'b0, rd_addr} < NUM_REGS_A);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam reg_mode_e MODE = reg_mode_e'(REG_MODES[i*3 +: 3]);
    localparam bit IS_RW    = (MODE == MODE_RW);
    localparam bit IS_W1C   = (MODE == MODE_W1C);
    localparam bit IS_W1S   = (MODE == MODE_W1S);
    localparam bit IS_PULSE = (MODE == MODE_PULSE);
    localparam bit IS_RO    = !(IS_RW || IS_W1C || IS_W1S || IS_PULSE);
    // PULSE registers always come out of reset cleared.
    localparam logic [DATA_WIDTH-1:0] RST_VAL =
      IS_PULSE ? '0 : RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];

    logic                  wr_hit;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] wr_bits;
    logic [DATA_WIDTH-1:0] set_bits;
    logic [DATA_WIDTH-1:0] active_q;
    logic [DATA_WIDTH-1:0] active_d;

    assign wr_hit   = wr_en && (wr_addr == ADDR_WIDTH'(i));
    assign wr_mask  = wr_hit ? byte_mask : '0;
    assign wr_bits  = wdata & wr_mask;
    assign set_bits = IS_W1C ? hw_set[i*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef REG_BANK_SHADOW_EN
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] shadow_d;

    // RW/W1S writes go to the shadow; commit forwards the post-write shadow
    // so a write coinciding with commit reaches the active copy too.
    always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (IS_RW) begin
        shadow_d = (shadow_q & ~wr_mask) | wr_bits;
        active_d = commit ? shadow_d : active_q;
      end else if (IS_W1S) begin
        shadow_d = shadow_q | wr_bits;
        active_d = commit ? shadow_d : active_q;
      end else if (IS_W1C) begin
        active_d = (active_q & ~wr_bits) | set_bits;
      end else if (IS_PULSE) begin
        active_d = wr_bits;
      end
    end

    // Shadow copy storage.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        shadow_q <= RST_VAL;
      end else begin
        shadow_q <= shadow_d;
      end
    end
`else
    // Next-state per access mode. W1C applies the clear first so that a
    // coincident hw_set bit wins. PULSE holds only this cycle's written ones.
    always_comb begin
      active_d = active_q;
      if (IS_RW) begin
        active_d = (active_q & ~wr_mask) | wr_bits;
      end else if (IS_W1S) begin
        active_d = active_q | wr_bits;
      end else if (IS_W1C) begin
        active_d = (active_q & ~wr_bits) | set_bits;
      end else if (IS_PULSE) begin
        active_d = wr_bits;
      end
    end
`endif

    // Active copy storage; RO registers simply keep their reset value.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        active_q <= RST_VAL;
      end else begin
        active_q <= active_d;
      end
    end

    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = active_q;
    assign read_val[i] = IS_RO ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : active_q;
  end

  // Read select; out-of-range addresses match no register and yield 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) begin
        rd_mux = read_val[i];
      end
    end
  end

  // Registered read response and address-error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
      addr_err <= (wr_en && !wr_in_range) || (rd_en && !rd_in_range);
    end
  end

endmodule

// File: tb/tb_axi4lite_register_bank.sv
// tb_axi4lite_register_bank
//
// Directed bench for axi4lite_register_bank with six registers:
//   reg0 RW, reg1 RW (reset 0xDEADBEEF), reg2 W1C, reg3 PULSE, reg4 W1S,
//   reg5 RO (stored reset value 0x00005A5A, reads return hw_in).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.

module tb_axi4lite_register_bank;

  localparam int DW = 32;
  localparam int NR = 6;
  localparam int AW = 3;
  localparam logic [NR*3-1:0]  MODES = {3'd1, 3'd3, 3'd4, 3'd2, 3'd0, 3'd0};
  localparam logic [NR*DW-1:0] RSTV  = {32'h0000_5A5A, 32'h0, 32'h0, 32'h0,
                                        32'hDEAD_BEEF, 32'h0};

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW/8-1:0]  wstrb;
  logic [DW-1:0]    wdata;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic             addr_err;
  logic [NR*DW-1:0] hw_in;
  logic [NR*DW-1:0] hw_set;
  logic [NR*DW-1:0] regs_out;

  int vec_count;
  int miss_count;
  logic [DW-1:0] exp_regs [NR];

  axi4lite_register_bank #(
    .DATA_WIDTH   (DW),
    .NUM_REGS     (NR),
    .ADDR_WIDTH   (AW),
    .REG_MODES    (MODES),
    .RESET_VALUES (RSTV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wstrb    (wstrb),
    .wdata    (wdata),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .addr_err (addr_err),
    .hw_in    (hw_in),
    .hw_set   (hw_set),
    .regs_out (regs_out)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Compare every register on regs_out against the bench's expected image.
  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < NR; i++) begin
      checkOutput($sformatf("%s reg%0d", tag, i), regs_out[i*DW +: DW], exp_regs[i]);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one write (and optionally a read) for a single cycle.
  task automatic applyStimulus(input logic do_wr, input logic [AW-1:0] waddr,
                               input logic [3:0] strb, input logic [DW-1:0] data,
                               input logic do_rd, input logic [AW-1:0] raddr);
    wr_en   = do_wr;
    wr_addr = waddr;
    wstrb   = strb;
    wdata   = data;
    rd_en   = do_rd;
    rd_addr = raddr;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wstrb   = '0;
    wdata   = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    hw_in   = '0;
    hw_set  = '0;
    hw_in[5*DW +: DW] = 32'h1234_5678;
    exp_regs = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0000_5A5A};

    // Reset state.
    #23;
    checkOutput("reset rd_valid", {31'b0, rd_valid}, 32'h0);
    checkOutput("reset rd_data", rd_data, 32'h0);
    checkOutput("reset addr_err", {31'b0, addr_err}, 32'h0);
    checkAllRegs("reset");
    reset = 1'b1;
    tick();

    // Read of a reset value, then rd_valid drops.
    applyStimulus(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd1);
    checkOutput("rd1 valid", {31'b0, rd_valid}, 32'h1);
    checkOutput("rd1 data", rd_data, 32'hDEAD_BEEF);
    checkOutput("rd1 addr_err", {31'b0, addr_err}, 32'h0);
    tick();
    checkOutput("rd1 valid drop", {31'b0, rd_valid}, 32'h0);

    // RW with byte strobes.
    applyStimulus(1'b1, 3'd0, 4'hF, 32'hAAAA_AAAA, 1'b0, 3'd0);
    exp_regs[0] = 32'hAAAA_AAAA;
    checkAllRegs("rw full");
    applyStimulus(1'b1, 3'd0, 4'b0101, 32'h1122_3344, 1'b0, 3'd0);
    exp_regs[0] = 32'hAA22_AA44;
    checkAllRegs("rw strb");
    applyStimulus(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd0);
    checkOutput("rd0 data", rd_data, 32'hAA22_AA44);

    // W1C: hardware set, software clear, set wins over clear.
    hw_set[2*DW +: DW] = 32'h0F;
    hw_set[0*DW +: DW] = 32'hFFFF_FFFF;
    tick();
    hw_set = '0;
    exp_regs[2] = 32'h0F;
    checkAllRegs("w1c hwset");
    applyStimulus(1'b1, 3'd2, 4'hF, 32'h05, 1'b0, 3'd0);
    exp_regs[2] = 32'h0A;
    checkAllRegs("w1c clr");
    hw_set[2*DW +: DW] = 32'h02;
    applyStimulus(1'b1, 3'd2, 4'hF, 32'h02, 1'b0, 3'd0);
    hw_set = '0;
    checkAllRegs("w1c setwins");

    // PULSE: one cycle high, and readable in the cycle after the write.
    applyStimulus(1'b1, 3'd3, 4'hF, 32'h80, 1'b0, 3'd0);
    exp_regs[3] = 32'h80;
    checkAllRegs("pulse hi");
    applyStimulus(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd3);
    exp_regs[3] = 32'h0;
    checkOutput("pulse rd", rd_data, 32'h80);
    checkAllRegs("pulse lo");

    // W1S accumulates.
    applyStimulus(1'b1, 3'd4, 4'hF, 32'h1, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd4, 4'hF, 32'h2, 1'b0, 3'd0);
    exp_regs[4] = 32'h3;
    checkAllRegs("w1s");

    // Out-of-range read and write.
    applyStimulus(1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd7);
    checkOutput("oor rd valid", {31'b0, rd_valid}, 32'h1);
    checkOutput("oor rd data", rd_data, 32'h0);
    checkOutput("oor rd err", {31'b0, addr_err}, 32'h1);
    applyStimulus(1'b1, 3'd6, 4'hF, 32'hFFFF_FFFF, 1'b0, 3'd0);
    checkOutput("oor wr err", {31'b0, addr_err}, 32'h1);
    checkAllRegs("oor wr");
    tick();
    checkOutput("err drop", {31'b0, addr_err}, 32'h0);

    // RO: write ignored, read returns hw_in.
    applyStimulus(1'b1, 3'd5, 4'hF, 32'hFFFF_FFFF, 1'b1, 3'd5);
    checkAllRegs("ro wr");
    checkOutput("ro rd", rd_data, 32'h1234_5678);
    checkOutput("ro err", {31'b0, addr_err}, 32'h0);

    // Same-cycle read and write of one address returns the old value.
    applyStimulus(1'b1, 3'd0, 4'hF, 32'h0000_0055, 1'b1, 3'd0);
    exp_regs[0] = 32'h55;
    checkOutput("rdwr old", rd_data, 32'hAA22_AA44);
    checkAllRegs("rdwr");

    // Back-to-back reads.
    rd_en = 1'b1;
    rd_addr = 3'd1;
    tick();
    checkOutput("b2b0 valid", {31'b0, rd_valid}, 32'h1);
    checkOutput("b2b0 data", rd_data, 32'hDEAD_BEEF);
    rd_addr = 3'd4;
    tick();
    checkOutput("b2b1 valid", {31'b0, rd_valid}, 32'h1);
    checkOutput("b2b1 data", rd_data, 32'h3);
    rd_addr = 3'd0;
    tick();
    checkOutput("b2b2 valid", {31'b0, rd_valid}, 32'h1);
    checkOutput("b2b2 data", rd_data, 32'h55);

    // Reset asserted while a read response is showing.
    rd_addr = 3'd1;
    tick();
    rd_en = 1'b0;
    checkOutput("pre-rst valid", {31'b0, rd_valid}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst valid", {31'b0, rd_valid}, 32'h0);
    checkOutput("rst data", rd_data, 32'h0);
    exp_regs = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0000_5A5A};
    checkAllRegs("midrst");
    #4;
    reset = 1'b1;
    tick();
    checkOutput("post-rst valid", {31'b0, rd_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
